spiflash_arb: RTL and testbench
===============================

SPIFLASH_ARB -- requirements
Module: spiflash_arb

Interface
REQ-001 Parameter TIMEOUT, default 4096: maximum cycles spent in FETCH before the fetch is abandoned.
REQ-002 Parameter CACHE_EN, default 1: when 1, a one-word last-read cache is enabled; when 0, every request is a miss.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 m0_valid / m1_valid  in  1  read request from requester 0 / 1.
REQ-006 m0_addr / m1_addr  in  32  byte address of the request; only bits [23:2] are used.
REQ-007 m0_rdata / m1_rdata  out  32  read data returned to requester 0 / 1.
REQ-008 m0_ready / m1_ready  out  1  read-complete flag to requester 0 / 1.
REQ-009 f_valid  out  1  request to the flash reader.
REQ-010 f_addr  out  32  address to the flash reader, as {8'h00, addr[23:2], 2'b00}.
REQ-011 f_rdata  in  32  data from the flash reader.
REQ-012 f_ready  in  1  flash reader done flag; stays high until f_valid drops.
REQ-013 cache_inv  in  1  single-cycle pulse that clears the cache valid bit.
REQ-014 err  out  1  sticky timeout flag.

Function
REQ-015 The requester protocol SHALL be: hold valid and addr until ready is seen high; ready SHALL stay high until valid is seen low, then clear on the next edge.
REQ-016 The block SHALL implement states IDLE, HIT, FETCH, DONE and RELEASE.
REQ-017 IDLE, one requester valid: grant that requester.
REQ-018 IDLE, both valid: grant the requester not granted last; after reset, last = 1, so m0 wins the first tie.
REQ-019 On grant, a hit SHALL be cache_vld && tag == addr[23:2] && CACHE_EN; a hit goes to HIT, and a miss asserts f_valid/f_addr on the next edge and goes to FETCH.
REQ-020 HIT: load cached data into m<w>_rdata, set m<w>_ready, go to DONE; hit latency from valid to ready is 2 cycles.
REQ-021 FETCH, f_ready == 1: capture f_rdata into m<w>_rdata, cache data and tag.
REQ-022 On the same FETCH edge, set cache_vld, drop f_valid, set m<w>_ready, go to DONE.
REQ-023 FETCH timeout: the cycle counter starts at 0 on FETCH entry; at count == TIMEOUT-1 without f_ready, the block SHALL return 32'hFFFF_FFFF, set m<w>_ready and err, drop f_valid, leave the cache unchanged, and go to DONE.
REQ-024 DONE: when m<w>_valid == 0, clear m<w>_ready, record last = w, go to RELEASE.
REQ-025 RELEASE: go to IDLE only once f_ready == 0, so a stale f_ready is never accepted.
REQ-026 A requester dropping valid during FETCH SHALL NOT abort the fetch; the cache still fills, ready is not raised, and DONE exits on the next cycle.
REQ-027 A request from the non-granted requester SHALL wait; at most one transaction is outstanding at any time.
REQ-028 cache_inv clears cache_vld on the next edge.
REQ-029 cache_inv coincident with a fill: invalidate wins and cache_vld ends at 0.
REQ-030 cache_inv coincident with a hit grant: a miss is taken.
REQ-031 m<w>_rdata for the non-granted requester SHALL hold its previous value.
REQ-032 f_addr SHALL be stable while f_valid is high.

Reset
REQ-033 While resetn is low, the block SHALL be forced asynchronously to: state IDLE, f_valid 0, f_addr 0, m0/m1_ready 0, m0/m1_rdata 0, err 0, cache_vld 0, last 1, counter 0.
REQ-034 Reset asserted mid-FETCH SHALL drop f_valid immediately, with no ready to any requester.
REQ-035 After release, the first action is IDLE arbitration.

Verification
REQ-036 m0 reads 0x100 with a flash model returning 0xDEADBEEF after 60 cycles -> f_addr = 0x100, m0_ready high with m0_rdata = 0xDEADBEEF; m0 re-reads 0x100 -> no f_valid and m0_ready 2 cycles after valid.
REQ-037 m0 and m1 valid in the same cycle after reset -> m0 served first, m1 second; repeat the tie -> m1 first.
REQ-038 Hit on 0x100, then a cache_inv pulse, then a read of 0x100 -> f_valid asserted, a fresh fetch.
REQ-039 Flash model never asserts f_ready, TIMEOUT = 16 -> m1_ready on the 16th FETCH cycle with rdata 0xFFFFFFFF and err = 1 sticky; the next read of the same address misses.
REQ-040 resetn pulsed low mid-FETCH -> all outputs at reset values immediately, cache empty, next read misses.
REQ-041 f_ready held high 3 cycles after f_valid drops -> block stays in RELEASE and does not grant a pending m1 until f_ready == 0.

Source files
------------

// File: rtl/spiflash_arb.sv
// Two-requester read arbiter in front of a SPI flash reader, with an optional
// one-word last-read cache, a fetch timeout and a sticky timeout error flag.
module spiflash_arb #(
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned CACHE_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_m0_valid,
  input  logic [31:0] i_m0_addr,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ready,
  input  logic        i_m1_valid,
  input  logic [31:0] i_m1_addr,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ready,
  output logic        o_f_valid,
  output logic [31:0] o_f_addr,
  input  logic [31:0] i_f_rdata,
  input  logic        i_f_ready,
  input  logic        i_cache_inv,
  output logic        o_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HIT     = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]       r_state;
  logic             r_w;
  logic             r_last;
  logic             r_f_valid;
  logic [31:0]      r_f_addr;
  logic [1:0][31:0] r_rdata;
  logic [1:0]       r_ready;
  logic             r_err;
  logic             r_cache_vld;
  logic [21:0]      r_cache_tag;
  logic [31:0]      r_cache_data;
  logic [CW-1:0]    r_cnt;

  logic        w_any;
  logic        w_sel;
  logic [31:0] w_req_addr;
  logic        w_hit;
  logic        w_cur_valid;
  logic        w_timeout;
  logic        w_unused_addr;

  assign w_any      = i_m0_valid | i_m1_valid;
  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign w_sel      = (i_m0_valid && i_m1_valid) ? ~r_last : i_m1_valid;
  assign w_req_addr = w_sel ? i_m1_addr : i_m0_addr;
  // A coincident invalidate forces a miss so the grant never sees a dying entry.
  assign w_hit      = (CACHE_EN != 0) && r_cache_vld && !i_cache_inv &&
                      (r_cache_tag == w_req_addr[23:2]);
  assign w_cur_valid = r_w ? i_m1_valid : i_m0_valid;
  assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

  assign w_unused_addr = ^{i_m0_addr[31:24], i_m0_addr[1:0], i_m1_addr[31:24], i_m1_addr[1:0]};

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_w          <= 1'b0;
      r_last       <= 1'b1;
      r_f_valid    <= 1'b0;
      r_f_addr     <= '0;
      r_rdata      <= '0;
      r_ready      <= '0;
      r_err        <= 1'b0;
      r_cache_vld  <= 1'b0;
      r_cache_tag  <= '0;
      r_cache_data <= '0;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_w <= w_sel;
            if (w_hit) begin
              r_state <= S_HIT;
            end else begin
              r_f_valid <= 1'b1;
              r_f_addr  <= {8'h00, w_req_addr[23:2], 2'b00};
              r_cnt     <= '0;
              r_state   <= S_FETCH;
            end
          end
        end
        S_HIT: begin
          r_rdata[r_w] <= r_cache_data;
          r_ready[r_w] <= w_cur_valid;
          r_state      <= S_DONE;
        end
        S_FETCH: begin
          if (i_f_ready) begin
            r_rdata[r_w] <= i_f_rdata;
            r_cache_data <= i_f_rdata;
            r_cache_tag  <= r_f_addr[23:2];
            r_cache_vld  <= 1'b1;
            r_f_valid    <= 1'b0;
            // A requester that gave up still fills the cache but gets no ready.
            r_ready[r_w] <= w_cur_valid;
            r_state      <= S_DONE;
          end else if (w_timeout) begin
            r_rdata[r_w] <= 32'hFFFF_FFFF;
            r_ready[r_w] <= w_cur_valid;
            r_err        <= 1'b1;
            r_f_valid    <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!w_cur_valid) begin
            r_ready[r_w] <= 1'b0;
            r_last       <= r_w;
            r_state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Wait out a lingering f_ready so it cannot complete the next fetch.
          if (!i_f_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (i_cache_inv) r_cache_vld <= 1'b0;
    end
  end

  assign o_m0_rdata = r_rdata[0];
  assign o_m1_rdata = r_rdata[1];
  assign o_m0_ready = r_ready[0];
  assign o_m1_ready = r_ready[1];
  assign o_f_valid  = r_f_valid;
  assign o_f_addr   = r_f_addr;
  assign o_err      = r_err;

endmodule

// File: tb/tb_spiflash_arb.sv
// Directed bench for spiflash_arb: flash model, expected-result scoreboard,
// a default-timeout instance and a short-timeout instance for the timeout path.
module tb_spiflash_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [1:0]       vld;
  logic [1:0][31:0] adr;
  logic [1:0][31:0] rdat;
  logic [1:0]       rdy;
  logic             f_valid;
  logic [31:0]      f_addr;
  logic [31:0]      fl_rdata;
  logic             fl_ready;
  logic             cache_inv;
  logic             err;

  logic        b_vld0, b_vld1, b_inv, b_f_ready;
  logic [31:0] b_adr0, b_adr1, b_f_rdata;
  logic [31:0] b_rdat0, b_rdat1, b_fa;
  logic        b_rdy0, b_rdy1, b_fv, b_err;

  spiflash_arb u_dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_m0_valid (vld[0]),
    .i_m0_addr  (adr[0]),
    .o_m0_rdata (rdat[0]),
    .o_m0_ready (rdy[0]),
    .i_m1_valid (vld[1]),
    .i_m1_addr  (adr[1]),
    .o_m1_rdata (rdat[1]),
    .o_m1_ready (rdy[1]),
    .o_f_valid  (f_valid),
    .o_f_addr   (f_addr),
    .i_f_rdata  (fl_rdata),
    .i_f_ready  (fl_ready),
    .i_cache_inv(cache_inv),
    .o_err      (err)
  );

  spiflash_arb #(.TIMEOUT(16), .CACHE_EN(1)) u_dut_to (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_m0_valid (b_vld0),
    .i_m0_addr  (b_adr0),
    .o_m0_rdata (b_rdat0),
    .o_m0_ready (b_rdy0),
    .i_m1_valid (b_vld1),
    .i_m1_addr  (b_adr1),
    .o_m1_rdata (b_rdat1),
    .o_m1_ready (b_rdy1),
    .o_f_valid  (b_fv),
    .o_f_addr   (b_fa),
    .i_f_rdata  (b_f_rdata),
    .i_f_ready  (b_f_ready),
    .i_cache_inv(b_inv),
    .o_err      (b_err)
  );

  typedef struct packed {
    logic        m;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fl_delay = 60;
  int          fl_hold = 0;

  function automatic logic [31:0] fword(input logic [31:0] a);
    return (a[23:2] == 22'h40) ? 32'hDEAD_BEEF : {8'h5A, a[23:0]};
  endfunction

  // Flash reader model: answers fl_delay cycles after f_valid, holds ready
  // until f_valid drops plus fl_hold extra cycles.
  initial begin
    fl_ready = 1'b0;
    fl_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (f_valid && !fl_ready) begin
        for (int i = 1; i < fl_delay && f_valid; i++) begin
          @(posedge clk); #1;
        end
        if (f_valid) begin
          fl_rdata = fword(f_addr);
          fl_ready = 1'b1;
          while (f_valid) begin
            @(posedge clk); #1;
          end
          repeat (fl_hold) begin
            @(posedge clk); #1;
          end
          fl_ready = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input logic m, input logic [31:0] a);
    sb.push_back('{m: m, d: fword(a)});
    if (m) rq1.push_back(a);
    else   rq0.push_back(a);
  endtask

  // Runs queued requests on both ports until all are served; ready results are
  // checked in scoreboard order, which also checks the arbitration order.
  task automatic serve(input string tag, input int m1_delay, input bit inv,
                       output bit saw_f, output int lat0, output logic [31:0] fa);
    int   cyc   = 0;
    int   stale = 0;
    logic pfv   = f_valid;
    exp_t e;
    saw_f = 1'b0;
    lat0  = -1;
    fa    = 'x;
    while (cyc < 400) begin
      for (int m = 0; m < 2; m++) begin
        if (rdy[m]) begin
          if (vld[m]) begin
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            check({tag, "_order"}, 32'(m), 32'(e.m));
            check({tag, "_data"}, rdat[m], e.d);
            vld[m] = 1'b0;
            if (m == 0 && lat0 < 0) lat0 = cyc;
          end
        end else if (!vld[m] && (m == 0 ? rq0.size() : rq1.size()) > 0 &&
                     (m == 0 || cyc >= m1_delay)) begin
          adr[m] = (m == 0) ? rq0.pop_front() : rq1.pop_front();
          vld[m] = 1'b1;
          if (inv && cyc == 0) cache_inv = 1'b1;
        end
      end
      if (rq0.size() == 0 && rq1.size() == 0 && vld == 2'b00 && rdy == 2'b00) break;
      @(posedge clk); #1;
      cache_inv = 1'b0;
      cyc++;
      if (f_valid && !pfv) begin
        if (!saw_f) fa = f_addr;
        if (fl_ready) stale++;
      end
      if (f_valid) saw_f = 1'b1;
      pfv = f_valid;
    end
    check({tag, "_completed"}, 32'(cyc < 400), 32'd1);
    check({tag, "_stale_ready"}, 32'(stale), 32'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  bit          saw_f;
  int          lat0;
  int          n;
  logic [31:0] fa;

  initial begin
    resetn = 1'b0;
    vld = '0; adr = '0; cache_inv = 1'b0;
    b_vld0 = 1'b0; b_vld1 = 1'b0; b_adr0 = '0; b_adr1 = '0;
    b_inv = 1'b0; b_f_ready = 1'b0; b_f_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_f_addr", f_addr, 32'd0);
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_rdata0", rdat[0], 32'd0);
    check("rst_rdata1", rdat[1], 32'd0);
    check("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Cold miss with a 60-cycle flash, address bits outside [23:2] ignored.
    expect_rd(1'b0, 32'hAB00_0103);
    serve("miss100", 0, 1'b0, saw_f, lat0, fa);
    check("miss100_fetch", 32'(saw_f), 32'd1);
    check("miss100_f_addr", fa, 32'h0000_0100);
    check("miss100_latency", 32'(lat0), 32'd61);
    check("miss100_m1_rdata_hold", rdat[1], 32'd0);

    // Re-read hits the cache: no flash access, ready 2 cycles after valid.
    expect_rd(1'b0, 32'h0000_0100);
    serve("hit100", 0, 1'b0, saw_f, lat0, fa);
    check("hit100_nofetch", 32'(saw_f), 32'd0);
    check("hit100_latency", 32'(lat0), 32'd2);

    // Invalidate then re-read: fresh fetch; refill then hit again.
    fl_delay = 4;
    cache_inv = 1'b1;
    @(posedge clk); #1;
    cache_inv = 1'b0;
    expect_rd(1'b0, 32'h0000_0100);
    serve("inv_miss", 0, 1'b0, saw_f, lat0, fa);
    check("inv_miss_fetch", 32'(saw_f), 32'd1);
    expect_rd(1'b0, 32'h0000_0100);
    serve("refill_hit", 0, 1'b0, saw_f, lat0, fa);
    check("refill_hit_nofetch", 32'(saw_f), 32'd0);
    // Invalidate coincident with a would-be hit grant forces a miss.
    expect_rd(1'b0, 32'h0000_0100);
    serve("inv_grant", 0, 1'b1, saw_f, lat0, fa);
    check("inv_grant_fetch", 32'(saw_f), 32'd1);

    // Tie right after reset: m0 first; m0 re-requests so the next tie goes to m1.
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    expect_rd(1'b0, 32'h0000_0200);
    expect_rd(1'b1, 32'h0000_0300);
    expect_rd(1'b0, 32'h0000_0240);
    serve("tie", 0, 1'b0, saw_f, lat0, fa);

    // Lingering f_ready: pending m1 must wait until it falls.
    fl_delay = 8;
    fl_hold  = 3;
    expect_rd(1'b0, 32'h0000_0400);
    expect_rd(1'b1, 32'h0000_0500);
    serve("stale", 3, 1'b0, saw_f, lat0, fa);
    fl_hold = 0;

    // Reset mid-fetch: outputs return to reset values at once; cache empty.
    fl_delay = 60;
    adr[0] = 32'h0000_0700;
    vld[0] = 1'b1;
    n = 0;
    while (!f_valid && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstfetch_f_valid_up", 32'(f_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("rstfetch_f_valid", 32'(f_valid), 32'd0);
    check("rstfetch_f_addr", f_addr, 32'd0);
    check("rstfetch_ready", 32'(rdy), 32'd0);
    check("rstfetch_rdata0", rdat[0], 32'd0);
    check("rstfetch_err", 32'(err), 32'd0);
    vld[0] = 1'b0;
    @(posedge clk); #1;
    check("rstfetch_no_ready", 32'(rdy), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fl_delay = 4;
    expect_rd(1'b0, 32'h0000_0100);
    serve("post_rst", 0, 1'b0, saw_f, lat0, fa);
    check("post_rst_miss", 32'(saw_f), 32'd1);

    // Timeout on the TIMEOUT=16 instance: flash never answers.
    b_adr1 = 32'h0000_0600;
    b_vld1 = 1'b1;
    n = 0;
    while (!b_fv && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_f_valid", 32'(b_fv), 32'd1);
    n = 0;
    while (!b_rdy1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_rdata", b_rdat1, 32'hFFFF_FFFF);
    check("to_err", 32'(b_err), 32'd1);
    check("to_f_valid_drop", 32'(b_fv), 32'd0);
    b_vld1 = 1'b0;
    @(posedge clk); #1;
    check("to_ready_clear", 32'(b_rdy1), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", 32'(b_err), 32'd1);
    b_vld1 = 1'b1;
    n = 0;
    while (!b_fv && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_reread_miss", 32'(b_fv), 32'd1);
    n = 0;
    while (!b_rdy1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_reread_cycles", 32'(n), 32'd16);
    b_vld1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_err_final", 32'(b_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
